result_bcd_display: RTL and testbench



---
 rtl/result_bcd_display.sv | 156 +++++++++++++++
 tb/tb_result_bcd_display.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_bcd_display.sv
// Signed result to seven-segment display: sign-magnitude capture, serial double-dabble, segment decode.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module result_bcd_display #(
   parameter int unsigned W      = 11,
   parameter int unsigned DIGITS = 4
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [W-1:0]          Result,
   input  logic                  Overflow,
   output logic                  Busy,
   output logic                  Done,
   output logic [7*DIGITS-1:0]   Hex,
   output logic [6:0]            SignSeg
);

   localparam int unsigned BW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(W + 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

   state_t          state_q, state_d;
   logic            sign_q, ovf_q, mag_nz_q;
   logic [W-1:0]    mag_q, mag_n, mag_in;
   logic [BW-1:0]   bcd_q, bcd_n, bcd_adj;
   logic [CW-1:0]   cnt_q;
   logic            accept_c, shift_c, load_c;
   logic [7*DIGITS-1:0] hex_c;
   logic [6:0]      sign_c;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   // State register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (Start) state_d = S_CONV;
         S_CONV:  if (cnt_q == CW'(1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control strobes
   always_comb begin
      accept_c = 1'b0;
      shift_c  = 1'b0;
      load_c   = 1'b0;
      case (state_q)
         S_IDLE:  accept_c = Start;
         S_CONV:  shift_c  = 1'b1;
         S_DONE:  load_c   = 1'b1;
         default: ;
      endcase
   end

   // |Result| fits in W unsigned bits, including the most negative value
   assign mag_in = Result[W-1] ? W'(-Result) : Result;

   // One double-dabble step: correct nibbles >= 5, then shift
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      {bcd_n, mag_n} = {bcd_adj, mag_q} << 1;
   end

   // Segment decode of the finished conversion
   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      logic nz;
      nz = 1'b0;
`endif
      hex_c  = '1;
      sign_c = SEG_BLANK;
      if (ovf_q) begin
         hex_c[6:0] = SEG_E;
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
         for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            nz = nz | (bcd_q[4*i +: 4] != 4'd0) | (i == 0);
            if (nz) hex_c[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
         end
`else
         for (int i = 0; i < DIGITS; i++) begin
            hex_c[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
         end
`endif
         if (sign_q && mag_nz_q) sign_c = SEG_MINUS;
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sign_q   <= 1'b0;
         ovf_q    <= 1'b0;
         mag_nz_q <= 1'b0;
         mag_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Hex      <= '1;
         SignSeg  <= SEG_BLANK;
      end else begin
         Done <= load_c;
         if (accept_c) begin
            sign_q   <= Result[W-1];
            ovf_q    <= Overflow;
            mag_q    <= mag_in;
            mag_nz_q <= (Result != '0);
            bcd_q    <= '0;
            cnt_q    <= CW'(W);
            Busy     <= 1'b1;
         end
         if (shift_c) begin
            bcd_q <= bcd_n;
            mag_q <= mag_n;
            cnt_q <= cnt_q - CW'(1);
         end
         if (load_c) begin
            Hex     <= hex_c;
            SignSeg <= sign_c;
            Busy    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_result_bcd_display.sv
// Self-checking bench for result_bcd_display: decimal reference model feeding a scoreboard queue.
module tb_result_bcd_display;

   localparam int unsigned W      = 11;
   localparam int unsigned DIGITS = 4;
   localparam int          LAT    = 12;

   typedef struct packed {
      logic [7*DIGITS-1:0] hex;
      logic [6:0]          sign;
   } disp_t;

   logic                Clock;
   logic                Reset;
   logic                Start;
   logic [W-1:0]        Result;
   logic                Overflow;
   logic                Busy;
   logic                Done;
   logic [7*DIGITS-1:0] Hex;
   logic [6:0]          SignSeg;

   int    checks;
   int    errors;
   disp_t sb[$];
   logic [6:0] seg_tab [10];

   result_bcd_display #(.W(W), .DIGITS(DIGITS)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Result(Result), .Overflow(Overflow),
      .Busy(Busy), .Done(Done), .Hex(Hex), .SignSeg(SignSeg)
   );

   always #5 Clock = ~Clock;

   // Reference: decimal digits by division, independent of the shift-add algorithm
   function automatic disp_t model(input logic [W-1:0] r, input logic ovf);
      disp_t d;
      int    v, mag, p, dig;
      d.hex  = '1;
      d.sign = 7'b1111111;
      if (ovf) begin
         d.hex[6:0] = 7'b0000110;
         return d;
      end
      v   = r[W-1] ? int'(r) - (1 << W) : int'(r);
      mag = (v < 0) ? -v : v;
      p   = 1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         dig = (mag / p) % 10;
`ifdef LEADING_ZERO_BLANK_EN
         if (i == 0 || mag >= p) d.hex[7*i +: 7] = seg_tab[dig];
`else
         d.hex[7*i +: 7] = seg_tab[dig];
`endif
         p = p * 10;
      end
      if (v < 0) d.sign = 7'b0111111;
      return d;
   endfunction

   // Starts a conversion in the current cycle; returns in the cycle where Done is observed.
   task automatic run_conv(input logic [W-1:0] r, input logic ovf, input int again);
      int    edges;
      disp_t exp_d;
      Start = 1'b1; Result = r; Overflow = ovf;
      sb.push_back(model(r, ovf));
      @(posedge Clock); #1;
      Start = 1'b0;
      Result = ~r; Overflow = ~ovf;
      checks++;
      if (Busy !== 1'b1 || Done !== 1'b0) begin
         errors++;
         $display("FAIL accept: Busy=%b Done=%b required Busy=1 Done=0 (r=%h)", Busy, Done, r);
      end
      edges = 0;
      while (Done !== 1'b1 && edges < 40) begin
         Start = (edges == again);
         @(posedge Clock); #1;
         edges++;
      end
      Start = 1'b0;
      checks++;
      if (edges != LAT) begin
         errors++;
         $display("FAIL latency: got %0d edges, required %0d (r=%h)", edges, LAT, r);
      end
      if (Done !== 1'b1) begin
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      checks++;
      if (Busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_at_done: Busy=%b required 0", Busy);
      end
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: Done with no expected entry");
         return;
      end
      exp_d = sb.pop_front();
      if (Hex !== exp_d.hex) begin
         errors++;
         $display("FAIL hex: got %h required %h (r=%h ovf=%b)", Hex, exp_d.hex, r, ovf);
      end
      checks++;
      if (SignSeg !== exp_d.sign) begin
         errors++;
         $display("FAIL signseg: got %b required %b (r=%h ovf=%b)", SignSeg, exp_d.sign, r, ovf);
      end
   endtask

   task automatic check_idle(input int n, input string name);
      int seen;
      seen = 0;
      repeat (n) begin
         @(posedge Clock); #1;
         if (Done === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL %s: %0d extra Done cycles, required 0", name, seen);
      end
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      repeat (2) @(posedge Clock);
      #1;
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Hex !== '1 || SignSeg !== 7'b1111111) begin
         errors++;
         $display("FAIL reset: Busy=%b Done=%b Hex=%h SignSeg=%b required 0 0 all-ones 1111111",
                  Busy, Done, Hex, SignSeg);
      end
      Reset = 1'b0;
      @(posedge Clock); #1;
   endtask

   task automatic test_values;
      run_conv(11'h000, 1'b0, -1); check_idle(2, "zero_done_pulse");
      run_conv(11'h7FF, 1'b0, -1); check_idle(2, "neg1_done_pulse");
      run_conv(11'h400, 1'b0, -1); check_idle(2, "min_done_pulse");
      run_conv(11'h3FF, 1'b0, -1); check_idle(2, "max_done_pulse");
      run_conv(11'd7,   1'b0, -1); check_idle(2, "seven_done_pulse");
      for (int i = 0; i < 6; i++) begin
         run_conv(W'($urandom_range(0, (1 << W) - 1)), 1'b0, -1);
      end
      check_idle(2, "random_done_pulse");
   endtask

   task automatic test_overflow;
      run_conv(11'h123, 1'b1, -1);
      check_idle(2, "ovf_done_pulse");
      run_conv(11'h400, 1'b1, -1);
      check_idle(2, "ovf_neg_done_pulse");
   endtask

   task automatic test_ignore_start;
      run_conv(11'd456, 1'b0, 4);
      check_idle(W + 4, "start_while_busy");
      run_conv(11'h5AB, 1'b0, 11);
      check_idle(W + 4, "start_in_done_cycle");
   endtask

   task automatic test_back_to_back;
      run_conv(11'd999, 1'b0, -1);
      run_conv(11'h601, 1'b0, -1);
      run_conv(11'd10,  1'b0, -1);
      check_idle(W + 4, "back_to_back_tail");
   endtask

   task automatic test_reset_abort;
      Start = 1'b1; Result = 11'd321; Overflow = 1'b0;
      @(posedge Clock); #1;
      Start = 1'b0;
      repeat (5) @(posedge Clock);
      #1;
      Reset = 1'b1;
      #1;
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Hex !== '1 || SignSeg !== 7'b1111111) begin
         errors++;
         $display("FAIL reset_abort: Busy=%b Done=%b Hex=%h SignSeg=%b required 0 0 all-ones 1111111",
                  Busy, Done, Hex, SignSeg);
      end
      @(posedge Clock); #1;
      Reset = 1'b0;
      check_idle(W + 4, "reset_abort_no_done");
      checks++;
      if (Hex !== '1) begin
         errors++;
         $display("FAIL reset_abort_hold: Hex=%h required all-ones", Hex);
      end
      run_conv(11'h7F6, 1'b0, -1);
      check_idle(2, "after_abort_done_pulse");
   endtask

   initial begin
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      checks   = 0;
      errors   = 0;
      Clock    = 1'b0;
      Reset    = 1'b1;
      Start    = 1'b0;
      Result   = '0;
      Overflow = 1'b0;
      test_reset;
      test_values;
      test_overflow;
      test_ignore_start;
      test_back_to_back;
      test_reset_abort;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
